// File: rtl/fetch_stage_ctrl.sv
// Fetch stage with IF/ID pipeline register: drives a 1-cycle-latency instruction memory,
// holds on load-use stall (capturing the returning word in a skid entry) and flushes on redirect.
module fetch_stage_ctrl #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic            decode_valid,
  output logic [XLEN-1:0] decode_pc,
  output logic [31:0]     decode_instr,
  output logic [31:0]     stall_count
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic            if_valid_q, if_valid_d;
  logic            skid_valid_q, skid_valid_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic [31:0]     skid_instr_q, skid_instr_d;
  logic            dec_valid_q, dec_valid_d;
  logic [XLEN-1:0] dec_pc_q, dec_pc_d;
  logic [31:0]     dec_instr_q, dec_instr_d;
  logic [31:0]     stall_count_q, stall_count_d;

  assign imem_addr    = redirect_valid ? redirect_pc : pc_q;
  assign imem_req     = rst_n & (redirect_valid | ~stall);
  assign decode_valid = dec_valid_q;
  assign decode_pc    = dec_pc_q;
  assign decode_instr = dec_instr_q;
  assign stall_count  = stall_count_q;

  always_comb begin
    pc_d          = pc_q;
    if_pc_d       = if_pc_q;
    if_valid_d    = if_valid_q;
    skid_valid_d  = skid_valid_q;
    skid_pc_d     = skid_pc_q;
    skid_instr_d  = skid_instr_q;
    dec_valid_d   = dec_valid_q;
    dec_pc_d      = dec_pc_q;
    dec_instr_d   = dec_instr_q;
    stall_count_d = stall_count_q;

    if (redirect_valid) begin
      dec_valid_d  = 1'b0;
      dec_instr_d  = NOP_INSTR;
      skid_valid_d = 1'b0;
      if_pc_d      = redirect_pc;
      if_valid_d   = 1'b1;
      pc_d         = redirect_pc + XLEN'(4);
    end else if (stall) begin
      if_valid_d = 1'b0;
      // Only the word already in flight needs parking; later stall cycles issue no request.
      if (if_valid_q) begin
        skid_valid_d = 1'b1;
        skid_pc_d    = if_pc_q;
        skid_instr_d = imem_rdata;
      end
      if (stall_count_q != 32'hFFFF_FFFF) begin
        stall_count_d = stall_count_q + 32'd1;
      end
    end else begin
      if (skid_valid_q) begin
        dec_valid_d = 1'b1;
        dec_pc_d    = skid_pc_q;
        dec_instr_d = skid_instr_q;
      end else begin
        dec_valid_d = if_valid_q;
        dec_pc_d    = if_pc_q;
        dec_instr_d = if_valid_q ? imem_rdata : NOP_INSTR;
      end
      skid_valid_d = 1'b0;
      if_pc_d      = pc_q;
      if_valid_d   = 1'b1;
      pc_d         = pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      if_pc_q       <= '0;
      if_valid_q    <= 1'b0;
      skid_valid_q  <= 1'b0;
      skid_pc_q     <= '0;
      skid_instr_q  <= NOP_INSTR;
      dec_valid_q   <= 1'b0;
      dec_pc_q      <= '0;
      dec_instr_q   <= NOP_INSTR;
      stall_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      if_pc_q       <= if_pc_d;
      if_valid_q    <= if_valid_d;
      skid_valid_q  <= skid_valid_d;
      skid_pc_q     <= skid_pc_d;
      skid_instr_q  <= skid_instr_d;
      dec_valid_q   <= dec_valid_d;
      dec_pc_q      <= dec_pc_d;
      dec_instr_q   <= dec_instr_d;
      stall_count_q <= stall_count_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Directed bench for fetch_stage_ctrl: a vector table for reset/advance/stall/redirect,
// then hand-written sequences for redirect-over-stall, PC wraparound and reset mid-stall.
module tb_fetch_stage_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n, stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        decode_valid;
  logic [31:0] decode_pc, decode_instr, stall_count;

  int checks = 0;
  int failures = 0;

  fetch_stage_ctrl dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .decode_valid(decode_valid), .decode_pc(decode_pc), .decode_instr(decode_instr),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[31:2], 2'b11} ^ 32'h5A00_0000;
  endfunction

  // Synchronous instruction memory: data for the address requested at an edge appears after it.
  always @(posedge clk) if (imem_req) imem_rdata <= instr_of(imem_addr);

  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        exp_req;
    logic        chk_addr;
    logic [31:0] exp_addr;
    logic        exp_v;
    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(input logic r, input logic s, input logic rd, input logic [31:0] rpc,
                              input logic req, input logic ca, input logic [31:0] addr,
                              input logic v, input logic [31:0] pc, input logic [31:0] cnt);
    vec_t t;
    t.rst_n = r; t.stall = s; t.redir = rd; t.rpc = rpc;
    t.exp_req = req; t.chk_addr = ca; t.exp_addr = addr;
    t.exp_v = v; t.exp_pc = pc; t.exp_cnt = cnt;
    return t;
  endfunction

  task automatic chk(input string name, input int step, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s step=%0d got=%h want=%h", name, step, got, want);
    end
  endtask

  // One cycle: inputs driven at negedge, combinational outputs checked before the edge,
  // registered outputs checked 1ns after it.
  task automatic cycle(input int step, input vec_t t);
    rst_n = t.rst_n; stall = t.stall; redirect_valid = t.redir; redirect_pc = t.rpc;
    #1;
    chk("imem_req", step, {31'b0, imem_req}, {31'b0, t.exp_req});
    if (t.chk_addr) chk("imem_addr", step, imem_addr, t.exp_addr);
    @(posedge clk);
    #1;
    chk("decode_valid", step, {31'b0, decode_valid}, {31'b0, t.exp_v});
    chk("decode_instr", step, decode_instr, t.exp_v ? instr_of(t.exp_pc) : NOP);
    if (t.exp_v || !t.rst_n) chk("decode_pc", step, decode_pc, t.exp_pc);
    chk("stall_count", step, stall_count, t.exp_cnt);
    $display("step=%0d rst_n=%0b stall=%0b redir=%0b req=%0b addr=%h dv=%0b dpc=%h di=%h cnt=%0d",
             step, t.rst_n, t.stall, t.redir, imem_req, imem_addr, decode_valid, decode_pc,
             decode_instr, stall_count);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;

    //              rst stl rd  rpc       req ca addr          v  pc            cnt
    vecs[0]  = mk(0, 0, 0, 32'h0,   0, 0, 32'h0,        0, 32'h0,        0);
    vecs[1]  = mk(0, 0, 0, 32'h0,   0, 1, 32'h0,        0, 32'h0,        0);
    vecs[2]  = mk(1, 0, 0, 32'h0,   1, 1, 32'h0,        0, 32'h0,        0);
    vecs[3]  = mk(1, 0, 0, 32'h0,   1, 1, 32'h4,        1, 32'h0,        0);
    vecs[4]  = mk(1, 0, 0, 32'h0,   1, 1, 32'h8,        1, 32'h4,        0);
    vecs[5]  = mk(1, 0, 0, 32'h0,   1, 1, 32'hC,        1, 32'h8,        0);
    vecs[6]  = mk(1, 1, 0, 32'h0,   0, 1, 32'h10,       1, 32'h8,        1);
    vecs[7]  = mk(1, 0, 0, 32'h0,   1, 1, 32'h10,       1, 32'hC,        1);
    vecs[8]  = mk(1, 0, 0, 32'h0,   1, 1, 32'h14,       1, 32'h10,       1);
    vecs[9]  = mk(1, 1, 0, 32'h0,   0, 1, 32'h18,       1, 32'h10,       2);
    vecs[10] = mk(1, 1, 0, 32'h0,   0, 1, 32'h18,       1, 32'h10,       3);
    vecs[11] = mk(1, 1, 0, 32'h0,   0, 1, 32'h18,       1, 32'h10,       4);
    vecs[12] = mk(1, 0, 0, 32'h0,   1, 1, 32'h18,       1, 32'h14,       4);
    vecs[13] = mk(1, 0, 0, 32'h0,   1, 1, 32'h1C,       1, 32'h18,       4);
    vecs[14] = mk(1, 0, 0, 32'h0,   1, 1, 32'h20,       1, 32'h1C,       4);
    vecs[15] = mk(1, 0, 0, 32'h0,   1, 1, 32'h24,       1, 32'h20,       4);
    vecs[16] = mk(1, 0, 1, 32'h100, 1, 1, 32'h100,      0, 32'h0,        4);
    vecs[17] = mk(1, 0, 0, 32'h0,   1, 1, 32'h104,      1, 32'h100,      4);
    vecs[18] = mk(1, 0, 0, 32'h0,   1, 1, 32'h108,      1, 32'h104,      4);

    @(negedge clk);
    for (int i = 0; i < 19; i++) cycle(i, vecs[i]);

    // Redirect during a stall with the skid entry full: skid (0x108) must be dropped.
    cycle(100, mk(1, 1, 0, 32'h0,   0, 1, 32'h10C, 1, 32'h104, 5));
    cycle(101, mk(1, 1, 1, 32'h200, 1, 1, 32'h200, 0, 32'h0,   5));
    cycle(102, mk(1, 0, 0, 32'h0,   1, 1, 32'h204, 1, 32'h200, 5));
    cycle(103, mk(1, 0, 0, 32'h0,   1, 1, 32'h208, 1, 32'h204, 5));

    // PC wraparound: pc_q reaches 0xFFFF_FFFC and the following fetch is 0x0.
    cycle(200, mk(1, 0, 1, 32'hFFFF_FFF8, 1, 1, 32'hFFFF_FFF8, 0, 32'h0,         5));
    cycle(201, mk(1, 0, 0, 32'h0,         1, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFF8, 5));
    cycle(202, mk(1, 0, 0, 32'h0,         1, 1, 32'h0,         1, 32'hFFFF_FFFC, 5));
    cycle(203, mk(1, 0, 0, 32'h0,         1, 1, 32'h4,         1, 32'h0,         5));

    // Reset asserted in the middle of a stall clears decode, skid and counter.
    cycle(300, mk(1, 1, 0, 32'h0, 0, 1, 32'h8, 1, 32'h0, 6));
    cycle(301, mk(0, 1, 0, 32'h0, 0, 1, 32'h8, 0, 32'h0, 0));
    cycle(302, mk(1, 0, 0, 32'h0, 1, 1, 32'h0, 0, 32'h0, 0));
    cycle(303, mk(1, 0, 0, 32'h0, 1, 1, 32'h4, 1, 32'h0, 0));
    cycle(304, mk(1, 0, 0, 32'h0, 1, 1, 32'h8, 1, 32'h4, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout step=-1 got=%h want=%h", 32'h1, 32'h0);
    $fatal(1, "timeout");
  end

endmodule
